// File: rtl/diff_drive_sequencer_pkg.sv
// Shared definitions for the two-channel drive sequencer: op codes, direction
// levels, FSM states and the per-op channel target table.
package diff_drive_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_STOP   = 3'd0,
        OP_FWD    = 3'd1,
        OP_LEFT   = 3'd2,
        OP_RIGHT  = 3'd3,
        OP_ROTATE = 3'd4
    } op_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN_T = 2'd1,
        ST_RUN_C = 2'd2
    } state_e;

    typedef struct packed {
        logic drive_l;
        logic drive_r;
        logic dir_l;
        logic dir_r;
    } op_targets_t;

    function automatic op_e decode_op(input logic [2:0] code);
        op_e op;
        case (code)
            3'd1:    op = OP_FWD;
            3'd2:    op = OP_LEFT;
            3'd3:    op = OP_RIGHT;
            3'd4:    op = OP_ROTATE;
            default: op = OP_STOP;
        endcase
        return op;
    endfunction

    function automatic op_targets_t op_targets(input op_e op);
        op_targets_t t;
        case (op)
            OP_FWD:    t = '{drive_l: 1'b1, drive_r: 1'b1, dir_l: DIR_FWD, dir_r: DIR_FWD};
            OP_LEFT:   t = '{drive_l: 1'b0, drive_r: 1'b1, dir_l: DIR_FWD, dir_r: DIR_FWD};
            OP_RIGHT:  t = '{drive_l: 1'b1, drive_r: 1'b0, dir_l: DIR_FWD, dir_r: DIR_FWD};
            OP_ROTATE: t = '{drive_l: 1'b1, drive_r: 1'b1, dir_l: DIR_FWD, dir_r: DIR_REV};
            default:   t = '{drive_l: 1'b0, drive_r: 1'b0, dir_l: DIR_FWD, dir_r: DIR_FWD};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/diff_drive_sequencer_channel.sv
// One PWM output with slew-limited duty ramping and a direction bit that only
// flips while the channel is fully stopped.
module pwm_ramp_channel
    import diff_drive_sequencer_pkg::*;
#(
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned RAMP_STEP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] target,
    input  logic             tdir,
    input  logic             boundary,
    input  logic [PWM_W-1:0] pcnt,
    input  logic             estop,
    output logic             pwm,
    output logic             dir,
    output logic             duty_is_zero
);

    localparam logic [PWM_W:0] STEP =
        (PWM_W+1)'((RAMP_STEP > (1 << PWM_W)) ? (1 << PWM_W) : RAMP_STEP);

    logic [PWM_W-1:0] duty, duty_nxt;
    logic             dir_nxt;
    logic [PWM_W:0]   goal_x, duty_x, step_x;

    // A pending reversal drags the goal to zero; the flip itself happens at a
    // boundary that already sees zero duty, so ramp-up starts one period later.
    always_comb begin
        goal_x   = (tdir != dir) ? '0 : {1'b0, target};
        duty_x   = {1'b0, duty};
        duty_nxt = duty;
        dir_nxt  = dir;
        if (goal_x > duty_x)
            step_x = ((goal_x - duty_x) > STEP) ? (duty_x + STEP) : goal_x;
        else
            step_x = ((duty_x - goal_x) > STEP) ? (duty_x - STEP) : goal_x;
        if (estop) begin
            duty_nxt = '0;
        end else if (boundary) begin
            duty_nxt = step_x[PWM_W-1:0];
            if ((tdir != dir) && (duty == '0))
                dir_nxt = tdir;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty <= '0;
            dir  <= DIR_FWD;
        end else begin
            duty <= duty_nxt;
            dir  <= dir_nxt;
        end
    end

    assign pwm          = (pcnt < duty);
    assign duty_is_zero = (duty == '0);

endmodule

// File: rtl/diff_drive_sequencer.sv
// Two-motor drive sequencer: command handshake, manoeuvre timer, PWM period
// counter and two ramped PWM channels.
module diff_drive_sequencer
    import diff_drive_sequencer_pkg::*;
#(
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned TIME_W    = 6,
    parameter int unsigned RAMP_STEP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              estop,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [TIME_W-1:0] cmd_time,
    input  logic [PWM_W-1:0]  duty_max,
    output logic              motorL,
    output logic              motorR,
    output logic              dirL,
    output logic              dirR,
    output logic              busy,
    output logic              done
);

    localparam logic [PWM_W-1:0] PCNT_LAST = PWM_W'((1 << PWM_W) - 2);
    localparam logic [TIME_W:0]  TIMER_ONE = (TIME_W+1)'(1);

    logic [PWM_W-1:0] pcnt;
    logic             boundary;
    logic             alive;
    logic             accept;
    state_e           state, state_nxt;
    logic [TIME_W:0]  timer, timer_nxt;
    logic [PWM_W-1:0] tgt_l, tgt_r, tgt_l_nxt, tgt_r_nxt;
    logic             tdir_l, tdir_r, tdir_l_nxt, tdir_r_nxt;
    op_e              op;
    op_targets_t      req;
    logic             zero_l, zero_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt  <= '0;
            alive <= 1'b0;
        end else begin
            pcnt  <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
            alive <= 1'b1;
        end
    end

    assign boundary = (pcnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            timer  <= '0;
            tgt_l  <= '0;
            tgt_r  <= '0;
            tdir_l <= DIR_FWD;
            tdir_r <= DIR_FWD;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            tgt_l  <= tgt_l_nxt;
            tgt_r  <= tgt_r_nxt;
            tdir_l <= tdir_l_nxt;
            tdir_r <= tdir_r_nxt;
        end
    end

    // The timer is loaded one above the duration and never decremented on the
    // accept edge, so the count always begins at the first boundary after it.
    always_comb begin
        op         = decode_op(cmd_op);
        req        = op_targets(op);
        cmd_ready  = alive && !estop && (state != ST_RUN_T);
        accept     = cmd_valid && cmd_ready;
        done       = 1'b0;
        state_nxt  = state;
        timer_nxt  = timer;
        tgt_l_nxt  = tgt_l;
        tgt_r_nxt  = tgt_r;
        tdir_l_nxt = tdir_l;
        tdir_r_nxt = tdir_r;
        if (estop) begin
            state_nxt  = ST_IDLE;
            timer_nxt  = '0;
            tgt_l_nxt  = '0;
            tgt_r_nxt  = '0;
            tdir_l_nxt = DIR_FWD;
            tdir_r_nxt = DIR_FWD;
        end else if (accept) begin
            tgt_l_nxt  = req.drive_l ? duty_max : '0;
            tgt_r_nxt  = req.drive_r ? duty_max : '0;
            tdir_l_nxt = req.dir_l;
            tdir_r_nxt = req.dir_r;
            if (cmd_time != '0) begin
                state_nxt = ST_RUN_T;
                timer_nxt = {1'b0, cmd_time} + TIMER_ONE;
            end else begin
                state_nxt = (op == OP_STOP) ? ST_IDLE : ST_RUN_C;
                timer_nxt = '0;
            end
        end else if ((state == ST_RUN_T) && boundary) begin
            if (timer == TIMER_ONE) begin
                done       = 1'b1;
                state_nxt  = ST_IDLE;
                timer_nxt  = '0;
                tgt_l_nxt  = '0;
                tgt_r_nxt  = '0;
                tdir_l_nxt = DIR_FWD;
                tdir_r_nxt = DIR_FWD;
            end else begin
                timer_nxt = timer - TIMER_ONE;
            end
        end
    end

    pwm_ramp_channel #(.PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP)) u_left (
        .clk          (clk),
        .rst          (rst),
        .target       (tgt_l),
        .tdir         (tdir_l),
        .boundary     (boundary),
        .pcnt         (pcnt),
        .estop        (estop),
        .pwm          (motorL),
        .dir          (dirL),
        .duty_is_zero (zero_l)
    );

    pwm_ramp_channel #(.PWM_W(PWM_W), .RAMP_STEP(RAMP_STEP)) u_right (
        .clk          (clk),
        .rst          (rst),
        .target       (tgt_r),
        .tdir         (tdir_r),
        .boundary     (boundary),
        .pcnt         (pcnt),
        .estop        (estop),
        .pwm          (motorR),
        .dir          (dirR),
        .duty_is_zero (zero_r)
    );

    assign busy = (state != ST_IDLE) || !zero_l || !zero_r;

endmodule

// File: tb/tb_diff_drive_sequencer.sv
// Bench for diff_drive_sequencer: cycle-level reference model, per-cycle output
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_diff_drive_sequencer;

    localparam int PERIOD = 15;
    localparam int STEP   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       estop = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = '0;
    logic [5:0] cmd_time = '0;
    logic [3:0] duty_max = '0;
    logic       cmd_ready, motorL, motorR, dirL, dirR, busy, done;

    diff_drive_sequencer #(.PWM_W(4), .TIME_W(6), .RAMP_STEP(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .estop     (estop),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_time  (cmd_time),
        .duty_max  (duty_max),
        .motorL    (motorL),
        .motorR    (motorR),
        .dirL      (dirL),
        .dirR      (dirR),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int tcyc   = 0;
    int done_cnt = 0;

    // Reference model: mk is the cycle index since reset, so the PWM phase is
    // mk % PERIOD; a timed command completes at an absolute cycle (deadline).
    int mk = 0, m_en = 0, m_mode = 0, m_deadline = 0;
    int m_duty[2] = '{0, 0};
    int m_tgt[2]  = '{0, 0};
    int m_tdir[2] = '{0, 0};
    int m_dir[2]  = '{0, 0};

    function automatic bit m_ready();
        return (m_en != 0) && !estop && (m_mode != 1);
    endfunction

    function automatic bit m_done();
        return (m_mode == 1) && (mk == m_deadline) && !estop;
    endfunction

    always @(posedge clk) tcyc++;
    always @(negedge clk) if (done) done_cnt++;

    always @(posedge clk or negedge rst) begin
        bit bnd, acc;
        int op;
        if (!rst) begin
            mk = 0; m_en = 0; m_mode = 0; m_deadline = 0;
            m_duty = '{0, 0}; m_tgt = '{0, 0}; m_tdir = '{0, 0}; m_dir = '{0, 0};
        end else begin
            bnd = ((mk % PERIOD) == 0);
            acc = cmd_valid && m_ready();
            if (estop) begin
                m_duty = '{0, 0}; m_tgt = '{0, 0}; m_tdir = '{0, 0};
                m_mode = 0;
            end else begin
                if (bnd) begin
                    for (int c = 0; c < 2; c++) begin
                        if (m_tdir[c] != m_dir[c]) begin
                            if (m_duty[c] == 0) m_dir[c] = m_tdir[c];
                            else m_duty[c] = (m_duty[c] > STEP) ? m_duty[c] - STEP : 0;
                        end else if (m_duty[c] < m_tgt[c]) begin
                            m_duty[c] = (m_tgt[c] - m_duty[c] > STEP) ? m_duty[c] + STEP : m_tgt[c];
                        end else begin
                            m_duty[c] = (m_duty[c] - m_tgt[c] > STEP) ? m_duty[c] - STEP : m_tgt[c];
                        end
                    end
                end
                if (acc) begin
                    op = (int'(cmd_op) > 4) ? 0 : int'(cmd_op);
                    m_tgt[0]  = (op == 1 || op == 3 || op == 4) ? int'(duty_max) : 0;
                    m_tgt[1]  = (op == 1 || op == 2 || op == 4) ? int'(duty_max) : 0;
                    m_tdir[0] = 0;
                    m_tdir[1] = (op == 4) ? 1 : 0;
                    if (cmd_time != 0) begin
                        m_mode = 1;
                        m_deadline = mk + PERIOD - (mk % PERIOD) + PERIOD * int'(cmd_time);
                    end else begin
                        m_mode = (op == 0) ? 0 : 2;
                    end
                end else if (m_mode == 1 && mk == m_deadline) begin
                    m_tgt = '{0, 0}; m_tdir = '{0, 0};
                    m_mode = 0;
                end
            end
            mk++;
            m_en = 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [6:0] exp_v, act_v;
        int pc;
        pc = mk % PERIOD;
        exp_v = {m_ready(), pc < m_duty[0], pc < m_duty[1], m_dir[0] != 0, m_dir[1] != 0,
                 (m_mode != 0) || (m_duty[0] != 0) || (m_duty[1] != 0), m_done()};
        act_v = {cmd_ready, motorL, motorR, dirL, dirR, busy, done};
        total++;
        if (act_v === exp_v) passed++;
        else $display("FAIL outputs cycle %0d: got rdy,mL,mR,dL,dR,busy,done=%b expected %b",
                      mk, act_v, exp_v);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic next_bnd();
        int i;
        i = 0;
        do begin
            @(posedge clk); #1; i++;
        end while ((mk % PERIOD) != 1 && i < 40);
    endtask

    task automatic send(input string name, input int op, input int t, input int d);
        bit ok;
        ok = 0;
        cmd_op = 3'(op); cmd_time = 6'(t); duty_max = 4'(d); cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            if (cmd_ready) ok = 1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk(name, int'(ok), 1);
    endtask

    initial begin
        int t_high, t_done, dc0, highs;
        bit seen;

        // Reset and release.
        cyc(3);
        rst = 1'b1;
        cyc(2);
        chk("ready_after_reset", int'(cmd_ready), 1);
        chk("busy_after_reset", int'(busy), 0);

        // Timed FWD: ramp 8 -> 15, done 3 periods after the first boundary.
        send("acc_fwd_t3", 1, 3, 15);
        next_bnd();
        t_high = tcyc;
        chk("fwd_first_high", int'(motorL), 1);
        chk("model_duty_8", m_duty[0], 8);
        next_bnd();
        chk("model_duty_15", m_duty[1], 15);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) seen = 1; else cyc(1);
        end
        t_done = tcyc;
        chk("done_seen", int'(seen), 1);
        chk("done_latency", t_done - t_high, 44);
        next_bnd();
        next_bnd();
        chk("rampdown_7", m_duty[0], 7);
        next_bnd();
        chk("rampdown_0", m_duty[0], 0);
        chk("busy_after_rampdown", int'(busy), 0);
        chk("single_done", done_cnt, 1);

        // Continuous FWD then ROTATE: right reverses via zero.
        send("acc_fwd_c", 1, 0, 15);
        next_bnd(); next_bnd();
        chk("fwd_c_15", m_duty[0] + m_duty[1], 30);
        send("acc_rotate", 4, 0, 15);
        next_bnd();
        chk("rot_r_7", m_duty[1], 7);
        next_bnd();
        chk("rot_r_0", m_duty[1], 0);
        chk("rot_dir_still_fwd", int'(dirR), 0);
        next_bnd();
        chk("rot_dir_flip", int'(dirR), 1);
        next_bnd();
        chk("rot_r_8", m_duty[1], 8);
        next_bnd();
        chk("rot_r_15", m_duty[1], 15);
        chk("rot_l_15", m_duty[0], 15);
        chk("rot_dirl", int'(dirL), 0);

        // Emergency stop in RUN_T.
        send("acc_fwd_t20", 1, 20, 15);
        next_bnd(); next_bnd(); next_bnd(); next_bnd(); next_bnd();
        dc0 = done_cnt;
        estop = 1'b1;
        cyc(1);
        chk("estop_motors_low", int'(motorL) + int'(motorR), 0);
        chk("estop_ready_low", int'(cmd_ready), 0);
        cyc(40);
        chk("estop_no_done", done_cnt - dc0, 0);
        chk("estop_idle", int'(busy), 0);
        estop = 1'b0;
        #1;
        chk("estop_release_ready", int'(cmd_ready), 1);
        cyc(1);

        // Handshake blocked during RUN_T, then preemption in RUN_C.
        send("acc_fwd_t2", 1, 2, 15);
        dc0 = done_cnt;
        send("acc_left_after_t", 2, 0, 15);
        chk("accept_after_done", done_cnt - dc0, 1);
        send("acc_fwd_c2", 1, 0, 15);
        next_bnd(); next_bnd(); next_bnd();
        dc0 = done_cnt;
        send("acc_left_preempt", 2, 0, 15);
        chk("preempt_tl", m_tgt[0], 0);
        cyc(40);
        chk("preempt_no_done", done_cnt - dc0, 0);
        chk("preempt_l_zero", m_duty[0], 0);

        // Full duty and op code 6.
        send("acc_fwd_full", 1, 0, 15);
        next_bnd(); next_bnd(); next_bnd();
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            highs += int'(motorL);
            cyc(1);
        end
        chk("full_duty_highs", highs, 15);
        send("acc_op6", 6, 0, 9);
        cyc(60);
        chk("op6_idle", int'(busy), 0);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            highs += int'(motorL) + int'(motorR);
            cyc(1);
        end
        chk("zero_duty_highs", highs, 0);

        // Reset asserted mid-run.
        send("acc_fwd_t10", 1, 10, 15);
        next_bnd(); next_bnd();
        rst = 1'b0;
        #1;
        chk("reset_outputs_zero",
            int'({cmd_ready, motorL, motorR, dirL, dirR, busy, done}), 0);
        cyc(3);
        rst = 1'b1;
        cyc(2);
        chk("ready_after_rerun_reset", int'(cmd_ready), 1);
        chk("busy_after_rerun_reset", int'(busy), 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cmd_valid = ($urandom_range(0, 5) == 0);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_time  = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 4));
            duty_max  = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            estop     = ($urandom_range(0, 199) == 0);
            rst       = ($urandom_range(0, 1499) != 0);
            cyc(1);
        end
        cmd_valid = 1'b0;
        estop = 1'b0;
        rst = 1'b1;
        cyc(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
